alu_cmd_sequencer: RTL

Command-driven controller that initiates ALU operations. It is the issuing end of the ALU's Ain/Bin/ALUop → out/Z interface.
- Owns an 8×16 register file, a B-operand shifter and a registered status flag.
- Accepts one command at a time over a valid/ready handshake.
- Drives the external combinational ALU, captures its result and Z, and writes the result back.
- Sits between the top-level stimulus/decoder and the ALU in the lab datapath.

---
 rtl/alu_cmd_sequencer_pkg.sv | 22 ++
 rtl/alu_cmd_sequencer_if.sv | 38 +++
 rtl/alu_cmd_sequencer_regfile8.sv | 37 +++
 rtl/alu_cmd_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and default sizes for the ALU command sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NREGS  = 8;

    typedef enum logic [1:0] {ADD, SUB, AND, NOTB} alu_op_e;

    typedef enum logic [1:0] {NONE, LSL1, LSR1, ASR1} shift_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_WB,
        S_IMM
    } state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command handshake plus ALU Ain/Bin/ALUop -> out/Z bundle.
// Latency: wires only.
// Backpressure: cmd_ready low while the sequencer is busy.
interface alu_cmd_sequencer_if #(
    parameter int DATA_W = alu_seq_pkg::DEF_DATA_W,
    parameter int REG_AW = $clog2(alu_seq_pkg::DEF_NREGS)
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_imm_en;
    logic [DATA_W-1:0] cmd_imm;
    logic [1:0]        cmd_aluop;
    logic [1:0]        cmd_shift;
    logic [REG_AW-1:0] cmd_rn;
    logic [REG_AW-1:0] cmd_rm;
    logic [REG_AW-1:0] cmd_rd;
    logic              cmd_nowb;
    logic [DATA_W-1:0] alu_ain;
    logic [DATA_W-1:0] alu_bin;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_out;
    logic              alu_z;

    // stimulus / decoder side together with the external ALU
    modport master (
        output cmd_valid, cmd_imm_en, cmd_imm, cmd_aluop, cmd_shift,
               cmd_rn, cmd_rm, cmd_rd, cmd_nowb, alu_out, alu_z,
        input  cmd_ready, alu_ain, alu_bin, alu_op
    );

    // sequencer side
    modport slave (
        input  cmd_valid, cmd_imm_en, cmd_imm, cmd_aluop, cmd_shift,
               cmd_rn, cmd_rm, cmd_rd, cmd_nowb, alu_out, alu_z,
        output cmd_ready, alu_ain, alu_bin, alu_op
    );

endinterface

// File: rtl/alu_cmd_sequencer_regfile8.sv
// Register file: one synchronous write port, two combinational operand reads, one readback read.
// Latency: reads combinational; a write is visible the cycle after it is issued.
// Backpressure: none, always accepts a write.
module regfile8 #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [AW-1:0]     rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [AW-1:0]     rbk_addr,
    output logic [DATA_W-1:0] rbk_data
);

    logic [DATA_W-1:0] mem [NREGS];

    // storage: cleared by reset, single write per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd0_data = mem[rd0_addr];
    assign rd1_data = mem[rd1_addr];
    assign rbk_data = mem[rbk_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequences one command at a time through regfile -> shifter -> external ALU -> writeback (optional N/V flags: ALU_FLAGS_EN).
// Latency: done 1 cycle after accept for immediates, 4 cycles after accept for ALU commands.
// Backpressure: cmd_ready only in IDLE; fields are ignored unless cmd_valid && cmd_ready.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NREGS   = DEF_NREGS,
    localparam int REG_AW = $clog2(NREGS)
)(
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_sequencer_if.slave  bus,
    output logic                done,
    output logic                busy,
    output logic                status_z,
    input  logic [REG_AW-1:0]   rb_addr,
    output logic [DATA_W-1:0]   rb_data
`ifdef ALU_FLAGS_EN
    ,
    output logic                status_n,
    output logic                status_v
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] imm_q, a_q, b_q, c_q, b_shift;
    alu_op_e           op_q;
    shift_e            sh_q;
    logic [REG_AW-1:0] rn_q, rm_q, rd_q;
    logic              nowb_q;
    logic              accept;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata, rf_rd0, rf_rd1;

    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.alu_ain   = a_q;
    assign bus.alu_bin   = b_q;
    assign bus.alu_op    = op_q;

    regfile8 #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (rf_wdata),
        .rd0_addr (rn_q),
        .rd0_data (rf_rd0),
        .rd1_addr (rm_q),
        .rd1_data (rf_rd1),
        .rbk_addr (rb_addr),
        .rbk_data (rb_data)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next state, completion pulse and register-file write strobe
    always_comb begin
        state_d  = state_q;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);
        rf_we    = 1'b0;
        rf_wdata = c_q;
        case (state_q)
            S_IDLE: if (accept) state_d = bus.cmd_imm_en ? S_IMM : S_RD_A;
            S_IMM: begin
                rf_we    = 1'b1;
                rf_wdata = imm_q;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            S_RD_A: state_d = S_RD_B;
            S_RD_B: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB: begin
                rf_we   = !nowb_q;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // B-operand shifter, one-bit moves only
    always_comb begin
        b_shift = rf_rd1;
        case (sh_q)
            LSL1:    b_shift = {rf_rd1[DATA_W-2:0], 1'b0};
            LSR1:    b_shift = {1'b0, rf_rd1[DATA_W-1:1]};
            ASR1:    b_shift = {rf_rd1[DATA_W-1], rf_rd1[DATA_W-1:1]};
            default: b_shift = rf_rd1;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic v_next;

    // signed overflow of the ALU result, only meaningful for add/sub
    always_comb begin
        v_next = 1'b0;
        case (op_q)
            ADD: v_next = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (bus.alu_out[DATA_W-1] != a_q[DATA_W-1]);
            SUB: v_next = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (bus.alu_out[DATA_W-1] != a_q[DATA_W-1]);
            default: v_next = 1'b0;
        endcase
    end

    // N/V captured in the same cycle as Z
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_n <= 1'b0;
            status_v <= 1'b0;
        end else if (state_q == S_EXEC) begin
            status_n <= bus.alu_out[DATA_W-1];
            status_v <= v_next;
        end
    end
`endif

    // command latch, operand fetch and ALU result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q    <= '0;
            op_q     <= ADD;
            sh_q     <= NONE;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            nowb_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_z <= 1'b0;
        end else begin
            if (accept) begin
                imm_q  <= bus.cmd_imm;
                op_q   <= alu_op_e'(bus.cmd_aluop);
                sh_q   <= shift_e'(bus.cmd_shift);
                rn_q   <= bus.cmd_rn;
                rm_q   <= bus.cmd_rm;
                rd_q   <= bus.cmd_rd;
                nowb_q <= bus.cmd_nowb;
            end
            if (state_q == S_RD_A) a_q <= rf_rd0;
            if (state_q == S_RD_B) b_q <= b_shift;
            if (state_q == S_EXEC) begin
                c_q      <= bus.alu_out;
                status_z <= bus.alu_z;
            end
        end
    end

endmodule
